// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter: FSM state encoding,
// default memory geometry (32x16) and the requester-id width helper.
package mem_arb_pkg;

    // Memory geometry shared with the memory and the accumulator datapath.
    localparam int MEM_ADDR_W = 5;
    localparam int MEM_DATA_W = 16;

    // Arbiter FSM states, 2-bit encoding.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational requester picker: returns the first set request bit at or
// after the pointer, wrapping modulo NUM_REQ, as one-hot vector and index.
// Build macro: ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins)
// and ignores the pointer.
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_onehot,
    output logic [ID_W-1:0]    o_id
);

    int   w_idx;
    logic w_found;

    // Scan the requests starting at the pointer (or at 0 for fixed priority).
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it
        // unassigned, which would infer a latch.
        o_onehot = '0;
        o_id     = '0;
        w_found  = 1'b0;
        w_idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef ARB_FIXED_PRIO_EN
            w_idx = k;
`else
            w_idx = int'(i_ptr) + k;
            if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
`endif
            if (!w_found && i_req[w_idx[ID_W-1:0]]) begin
                w_found                      = 1'b1;
                o_id                         = w_idx[ID_W-1:0];
                o_onehot[w_idx[ID_W-1:0]]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between NUM_REQ requesters. One read or
// write is in flight at a time: IDLE -> ISSUE -> (WAIT x READ_LAT) -> DONE.
// All outputs are registers; reset clears them asynchronously, aborting any
// transaction in flight.
// Build macro: ARB_FIXED_PRIO_EN (fixed priority, no round-robin pointer).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = MEM_ADDR_W,
    parameter int DATA_W   = MEM_DATA_W,
    parameter int READ_LAT = 1
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        Req,
    input  logic [NUM_REQ-1:0]        ReqWrite,
    input  logic [NUM_REQ*ADDR_W-1:0] ReqAddress,
    input  logic [NUM_REQ*DATA_W-1:0] ReqData,
    output logic [NUM_REQ-1:0]        Grant,
    output logic [NUM_REQ-1:0]        Ack,
    output logic [DATA_W-1:0]         RspData,
    output logic [ADDR_W-1:0]         Address,
    output logic [DATA_W-1:0]         DataIN,
    output logic                      ReadEnable,
    output logic                      WriteEnable,
    input  logic [DATA_W-1:0]         DataOut
);

    localparam int ID_W = id_width(NUM_REQ);

    state_t              r_state;
    logic [NUM_REQ-1:0]  r_sel;
    logic [ID_W-1:0]     r_id;
    logic                r_wr;
    logic [1:0]          r_cnt;
    logic [NUM_REQ-1:0]  r_grant;
    logic [NUM_REQ-1:0]  r_ack;
    logic [DATA_W-1:0]   r_rsp;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_din;
    logic                r_re;
    logic                r_we;

    logic [ID_W-1:0]     w_ptr;
    logic [NUM_REQ-1:0]  w_sel_onehot;
    logic [ID_W-1:0]     w_sel_id;
    logic                w_sel_wr;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_data;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .i_req    (Req),
        .i_ptr    (w_ptr),
        .o_onehot (w_sel_onehot),
        .o_id     (w_sel_id)
    );

    // Route the winning requester's command fields out of the packed buses.
    always_comb begin
        w_sel_wr   = 1'b0;
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_sel_onehot[k]) begin
                w_sel_wr   = ReqWrite[k];
                w_sel_addr = ReqAddress[k*ADDR_W +: ADDR_W];
                w_sel_data = ReqData[k*DATA_W +: DATA_W];
            end
        end
    end

`ifdef ARB_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    logic [ID_W-1:0] r_ptr;

    // Round-robin pointer: moves past the requester just served.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_ptr <= '0;
        end else if (r_state == ST_DONE) begin
            r_ptr <= (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;
        end
    end

    assign w_ptr = r_ptr;
`endif

    // Transaction FSM; each branch loads the output registers for the state
    // being entered, so every output is registered.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_id    <= '0;
            r_wr    <= 1'b0;
            r_cnt   <= '0;
            r_grant <= '0;
            r_ack   <= '0;
            r_rsp   <= '0;
            r_addr  <= '0;
            r_din   <= '0;
            r_re    <= 1'b0;
            r_we    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            r_grant <= '0;
            r_ack   <= '0;
            r_re    <= 1'b0;
            r_we    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|Req) begin
                        r_state <= ST_ISSUE;
                        r_sel   <= w_sel_onehot;
                        r_id    <= w_sel_id;
                        r_wr    <= w_sel_wr;
                        r_grant <= w_sel_onehot;
                        r_addr  <= w_sel_addr;
                        r_din   <= w_sel_wr ? w_sel_data : '0;
                        r_we    <= w_sel_wr;
                        r_re    <= !w_sel_wr;
                    end
                end
                ST_ISSUE: begin
                    r_din <= '0;
                    if (r_wr) begin
                        r_state <= ST_DONE;
                        r_ack   <= r_sel;
                        r_addr  <= '0;
                        r_rsp   <= '0;
                    end else begin
                        r_state <= ST_WAIT;
                        r_cnt   <= 2'(READ_LAT);
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == 2'd1) begin
                        r_state <= ST_DONE;
                        r_rsp   <= DataOut;
                        r_ack   <= r_sel;
                        r_addr  <= '0;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_rsp   <= '0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign Grant       = r_grant;
    assign Ack         = r_ack;
    assign RspData     = r_rsp;
    assign Address     = r_addr;
    assign DataIN      = r_din;
    assign ReadEnable  = r_re;
    assign WriteEnable = r_we;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (NUM_REQ=2, READ_LAT=1): a table
// of single transactions checked through a scoreboard queue, plus hand
// sequences for reset, contention, abort, dropped Req and held Req.
module tb_mem_port_arbiter;

    localparam int NUM_REQ  = 2;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 16;
    localparam int READ_LAT = 1;

    logic                      Clock;
    logic                      Reset;
    logic [NUM_REQ-1:0]        Req;
    logic [NUM_REQ-1:0]        ReqWrite;
    logic [NUM_REQ*ADDR_W-1:0] ReqAddress;
    logic [NUM_REQ*DATA_W-1:0] ReqData;
    logic [NUM_REQ-1:0]        Grant;
    logic [NUM_REQ-1:0]        Ack;
    logic [DATA_W-1:0]         RspData;
    logic [ADDR_W-1:0]         Address;
    logic [DATA_W-1:0]         DataIN;
    logic                      ReadEnable;
    logic                      WriteEnable;
    logic [DATA_W-1:0]         DataOut;

    mem_port_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .READ_LAT (READ_LAT)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Req         (Req),
        .ReqWrite    (ReqWrite),
        .ReqAddress  (ReqAddress),
        .ReqData     (ReqData),
        .Grant       (Grant),
        .Ack         (Ack),
        .RspData     (RspData),
        .Address     (Address),
        .DataIN      (DataIN),
        .ReadEnable  (ReadEnable),
        .WriteEnable (WriteEnable),
        .DataOut     (DataOut)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Memory model: registered read (one cycle), write on strobe.
    logic [DATA_W-1:0] mem [32];
    initial begin
        for (int a = 0; a < 32; a++) mem[a] = 16'hC000 | 16'(a);
        mem[31] = 16'h1234;
    end
    always @(posedge Clock) begin
        if (WriteEnable) mem[Address] <= DataIN;
        if (ReadEnable)  DataOut      <= mem[Address];
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle protocol invariants while out of reset.
    always @(negedge Clock) begin
        if (Reset) begin
            check("invariants",
                  {63'd0, !(ReadEnable && WriteEnable) && $onehot0(Grant) && $onehot0(Ack)
                          && (Ack == '0 || Address == '0)
                          && ((ReadEnable || WriteEnable) == (Grant != '0))},
                  64'd1);
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    typedef struct {
        logic [NUM_REQ-1:0] ack;
        logic [DATA_W-1:0]  rsp;
        int                 lat;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        int                id;
        bit                wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] exp_rsp;
    } vec_t;
    vec_t vecs[9];

    task automatic set_req(input int id, input bit wr, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] data);
        Req[id]                      = 1'b1;
        ReqWrite[id]                 = wr;
        ReqAddress[id*ADDR_W +: ADDR_W] = addr;
        ReqData[id*DATA_W +: DATA_W] = data;
    endtask

    // One transaction from an IDLE cycle: check issue cycle, Ack, data, latency.
    task automatic run_txn(input vec_t v);
        exp_t e;
        exp_t got;
        int   cyc;
        bit   done;
        set_req(v.id, v.wr, v.addr, v.data);
        e.ack = NUM_REQ'(1) << v.id;
        e.rsp = v.exp_rsp;
        e.lat = v.wr ? 2 : 2 + READ_LAT;
        sb_q.push_back(e);
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 20) begin
            @(negedge Clock);
            cyc++;
            if (Grant != '0) begin
                check("issue_grant", 64'(Grant), 64'(e.ack));
                check("issue_we", 64'(WriteEnable), 64'(v.wr));
                check("issue_re", 64'(ReadEnable), 64'(!v.wr));
                check("issue_addr", 64'(Address), 64'(v.addr));
                check("issue_din", 64'(DataIN), v.wr ? 64'(v.data) : 64'd0);
            end
            if (Ack != '0 && sb_q.size() > 0) begin
                got = sb_q.pop_front();
                check("txn_ack", 64'(Ack), 64'(got.ack));
                check("txn_rsp", 64'(RspData), 64'(got.rsp));
                check("txn_latency", 64'(cyc), 64'(got.lat));
                Req[v.id] = 1'b0;
                done = 1'b1;
            end
        end
        check("txn_ack_timeout", 64'(done), 64'd1);
        Req[v.id] = 1'b0;
        @(negedge Clock);
    endtask

    initial begin
        exp_t e;
        int   n_grant;
        int   n_ack;
        int   exp_id;
        bit   seen;

        Reset      = 1'b0;
        Req        = '0;
        ReqWrite   = '0;
        ReqAddress = '0;
        ReqData    = '0;

        vecs[0] = '{0, 1'b1, 5'd7,  16'hA5A5, 16'h0000};
        vecs[1] = '{1, 1'b0, 5'd31, 16'h0000, 16'h1234};
        vecs[2] = '{0, 1'b0, 5'd7,  16'h0000, 16'hA5A5};
        vecs[3] = '{1, 1'b1, 5'd0,  16'hFFFF, 16'h0000};
        vecs[4] = '{1, 1'b0, 5'd0,  16'h0000, 16'hFFFF};
        vecs[5] = '{0, 1'b0, 5'd3,  16'h0000, 16'hC003};
        vecs[6] = '{0, 1'b1, 5'd31, 16'h0001, 16'h0000};
        vecs[7] = '{1, 1'b0, 5'd31, 16'h0000, 16'h0001};
        vecs[8] = '{0, 1'b0, 5'd30, 16'h0000, 16'hC01E};

        // Reset held with both requesting: every output stays 0.
        set_req(0, 1'b0, 5'd5, 16'h0);
        set_req(1, 1'b0, 5'd6, 16'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            check("reset_outputs",
                  64'({Grant, Ack, RspData, Address, DataIN, ReadEnable, WriteEnable}), 64'd0);
        end
        Reset = 1'b1;

        // Contention: both reads held; grants alternate starting with 0.
        n_grant = 0;
        n_ack   = 0;
        for (int c = 0; c < 40 && n_ack < 4; c++) begin
            @(negedge Clock);
            if (Grant != '0) begin
`ifdef ARB_FIXED_PRIO_EN
                exp_id = 0;
`else
                exp_id = n_grant % 2;
`endif
                check("rr_grant", 64'(Grant), 64'(NUM_REQ'(1) << exp_id));
                e.ack = NUM_REQ'(1) << exp_id;
                e.rsp = (exp_id == 0) ? 16'hC005 : 16'hC006;
                e.lat = 0;
                sb_q.push_back(e);
                n_grant++;
            end
            if (Ack != '0 && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("rr_ack", 64'(Ack), 64'(e.ack));
                check("rr_rsp", 64'(RspData), 64'(e.rsp));
                n_ack++;
            end
        end
        check("rr_ack_count", 64'(n_ack), 64'd4);
        Req = '0;
        sb_q.delete();
        @(negedge Clock);

        // Table-driven single transactions.
        for (int v = 0; v < 9; v++) run_txn(vecs[v]);

        // Abort: reset during WAIT drops strobes and Ack immediately.
        set_req(1, 1'b0, 5'd31, 16'h0);
        @(negedge Clock);
        check("abort_issue_re", 64'(ReadEnable), 64'd1);
        @(negedge Clock);
        #2;
        Reset = 1'b0;
        Req   = '0;
        #1;
        check("abort_async",
              64'({Grant, Ack, RspData, Address, DataIN, ReadEnable, WriteEnable}), 64'd0);
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            check("abort_no_ack", 64'({Ack, Grant}), 64'd0);
        end

        // Pointer back at 0: both request, requester 0 wins; both then drop
        // Req right after the grant and requester 0 is still acknowledged.
        set_req(0, 1'b0, 5'd3, 16'h0);
        set_req(1, 1'b0, 5'd4, 16'h0);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge Clock);
            if (Grant != '0) begin
                check("post_abort_grant", 64'(Grant), 64'd1);
                Req  = '0;
                seen = 1'b1;
            end
        end
        check("post_abort_grant_seen", 64'(seen), 64'd1);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge Clock);
            if (Ack != '0) begin
                check("dropped_req_ack", 64'(Ack), 64'd1);
                check("dropped_req_rsp", 64'(RspData), 64'hC003);
                seen = 1'b1;
            end
        end
        check("dropped_req_ack_seen", 64'(seen), 64'd1);
        @(negedge Clock);

        // Req held through Ack: same requester re-granted in the next IDLE.
        set_req(1, 1'b1, 5'd9, 16'h5A5A);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge Clock);
            if (Ack != '0) begin
                check("hold_ack", 64'(Ack), 64'd2);
                seen = 1'b1;
            end
        end
        check("hold_ack_seen", 64'(seen), 64'd1);
        @(negedge Clock);
        check("hold_idle_gap", 64'({Grant, Ack}), 64'd0);
        @(negedge Clock);
        check("hold_regrant", 64'(Grant), 64'd2);
        check("hold_regrant_we", 64'(WriteEnable), 64'd1);
        Req = '0;
        @(negedge Clock);
        check("hold_second_ack", 64'(Ack), 64'd2);
        @(negedge Clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
